conv2d_seq_ctrl: RTL and testbench

//   Sequencer for the streaming 5x5 FP16 conv2d datapath (line-buffered, no stall input).

---
 rtl/conv2d_seq_ctrl_if.sv | 27 ++
 rtl/conv2d_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_conv2d_seq_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/conv2d_seq_ctrl_if.sv
// Control/tag bundle between the job host and the conv2d sequencer.
// master = host issuing start; slave = sequencer driving status, pixel reads and output tags.
interface conv2d_seq_ctrl_if #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned OADDR_W = 12,
    parameter int unsigned MAP_W   = 2
);
    logic               start;
    logic               busy;
    logic               done;
    logic [MAP_W-1:0]   map_sel;
    logic               pix_rd_en;
    logic [ADDR_W-1:0]  pix_rd_addr;
    logic               y_valid;
    logic [MAP_W-1:0]   y_map;
    logic [OADDR_W-1:0] y_addr;

    modport master (
        output start,
        input  busy, done, map_sel, pix_rd_en, pix_rd_addr, y_valid, y_map, y_addr
    );

    modport slave (
        input  start,
        output busy, done, map_sel, pix_rd_en, pix_rd_addr, y_valid, y_map, y_addr
    );
endinterface

// File: rtl/conv2d_seq_ctrl.sv
// Sequencer for the streaming 5x5 conv2d datapath: walks the feature map out of pixel RAM
// once per output map and tags the window-complete results that emerge D cycles later.
module conv2d_seq_ctrl #(
    parameter int unsigned IMG_W    = 28,
    parameter int unsigned IMG_H    = 28,
    parameter int unsigned K        = 5,
    parameter int unsigned N_MAPS   = 4,
    parameter int unsigned MEM_LAT  = 1,
    parameter int unsigned PIPE_LAT = 4,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned OADDR_W  = 12,
    parameter int unsigned MAP_W    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    conv2d_seq_ctrl_if.slave   seq
);

    localparam int unsigned D    = MEM_LAT + PIPE_LAT;
    localparam int unsigned R_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned C_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned DC_W = (D > 1) ? $clog2(D) : 1;

    localparam logic [R_W-1:0]   R_LAST   = R_W'(IMG_H - 1);
    localparam logic [C_W-1:0]   C_LAST   = C_W'(IMG_W - 1);
    localparam logic [R_W-1:0]   R_WIN    = R_W'(K - 1);
    localparam logic [C_W-1:0]   C_WIN    = C_W'(K - 1);
    localparam logic [DC_W-1:0]  DC_LAST  = DC_W'(D - 1);
    localparam logic [MAP_W-1:0] MAP_LAST = MAP_W'(N_MAPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_n;

    logic [R_W-1:0]     row;
    logic [C_W-1:0]     col;
    logic [ADDR_W-1:0]  addr;
    logic [DC_W-1:0]    dcnt;
    logic [MAP_W-1:0]   map;
    logic [OADDR_W-1:0] oaddr;

    logic               last_pix;
    logic               drain_end;
    logic               win_ok;

    logic               vld_dl  [D];
    logic [MAP_W-1:0]   map_dl  [D];
    logic [OADDR_W-1:0] oaddr_dl[D];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        last_pix  = (row == R_LAST) && (col == C_LAST);
        drain_end = (dcnt == DC_LAST);
        win_ok    = (state == STREAM) && (row >= R_WIN) && (col >= C_WIN);
        case (state)
            IDLE:    if (seq.start) state_n = STREAM;
            STREAM:  if (last_pix) state_n = DRAIN;
            DRAIN:   if (drain_end) state_n = (map == MAP_LAST) ? DONE : STREAM;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // oaddr runs across maps, so it is only cleared when a new job is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row   <= '0;
            col   <= '0;
            addr  <= '0;
            dcnt  <= '0;
            map   <= '0;
            oaddr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (seq.start) begin
                        row   <= '0;
                        col   <= '0;
                        addr  <= '0;
                        dcnt  <= '0;
                        map   <= '0;
                        oaddr <= '0;
                    end
                end
                STREAM: begin
                    dcnt <= '0;
                    if (win_ok) oaddr <= oaddr + OADDR_W'(1);
                    if (last_pix) begin
                        row  <= '0;
                        col  <= '0;
                        addr <= '0;
                    end else begin
                        addr <= addr + ADDR_W'(1);
                        if (col == C_LAST) begin
                            col <= '0;
                            row <= row + R_W'(1);
                        end else begin
                            col <= col + C_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_end) begin
                        dcnt <= '0;
                        if (map != MAP_LAST) map <= map + MAP_W'(1);
                    end else begin
                        dcnt <= dcnt + DC_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag delay line; invalid slots carry zeros so y_map/y_addr idle at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < D; i++) begin
                vld_dl[i]   <= 1'b0;
                map_dl[i]   <= '0;
                oaddr_dl[i] <= '0;
            end
        end else begin
            vld_dl[0]   <= win_ok;
            map_dl[0]   <= win_ok ? map : '0;
            oaddr_dl[0] <= win_ok ? oaddr : '0;
            for (int unsigned i = 1; i < D; i++) begin
                vld_dl[i]   <= vld_dl[i-1];
                map_dl[i]   <= map_dl[i-1];
                oaddr_dl[i] <= oaddr_dl[i-1];
            end
        end
    end

    assign seq.busy        = (state != IDLE);
    assign seq.done        = (state == DONE);
    assign seq.pix_rd_en   = (state == STREAM);
    assign seq.pix_rd_addr = addr;
    assign seq.map_sel     = map;
    assign seq.y_valid     = vld_dl[D-1];
    assign seq.y_map       = map_dl[D-1];
    assign seq.y_addr      = oaddr_dl[D-1];

endmodule

// File: tb/tb_conv2d_seq_ctrl.sv
// Bench for conv2d_seq_ctrl: per-cycle job timeline model plus a y_valid scoreboard fed by
// a reference one-hot 5x5 convolution over a random FP16 image.
module tb_conv2d_seq_ctrl;

    localparam int W    = 28;
    localparam int H    = 28;
    localparam int K    = 5;
    localparam int N    = 4;
    localparam int MLAT = 1;
    localparam int PLAT = 4;
    localparam int D    = MLAT + PLAT;
    localparam int WH   = W * H;
    localparam int P    = WH + D;
    localparam int OW   = W - K + 1;
    localparam int OH   = H - K + 1;
    localparam int HN   = 16384;

    typedef struct {
        int          cyc;
        int          map;
        int          addr;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   vecs = 0;
    int   miscmp = 0;
    int   job_s = 0;
    bit   job_valid = 1'b0;

    logic [15:0] img [WH];
    int          wt  [N][K][K];
    exp_t        sb  [$];
    logic        en_h   [HN];
    logic [9:0]  addr_h [HN];
    logic [1:0]  map_h  [HN];

    conv2d_seq_ctrl_if #(.ADDR_W(10), .OADDR_W(12), .MAP_W(2)) seq ();

    conv2d_seq_ctrl #(
        .IMG_W(W), .IMG_H(H), .K(K), .N_MAPS(N), .MEM_LAT(MLAT), .PIPE_LAT(PLAT),
        .ADDR_W(10), .OADDR_W(12), .MAP_W(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .seq   (seq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},    32'(seq.busy),        0);
        chk({tag, "_done"},    32'(seq.done),        0);
        chk({tag, "_map_sel"}, 32'(seq.map_sel),     0);
        chk({tag, "_rd_en"},   32'(seq.pix_rd_en),   0);
        chk({tag, "_rd_addr"}, 32'(seq.pix_rd_addr), 0);
        chk({tag, "_y_valid"}, 32'(seq.y_valid),     0);
        chk({tag, "_y_map"},   32'(seq.y_map),       0);
        chk({tag, "_y_addr"},  32'(seq.y_addr),      0);
    endtask

    // Reference conv: one-hot kernel, zero bias, so the result is the selected FP16 pixel.
    function automatic logic [15:0] ref_conv(input int m, input int orow, input int ocol);
        logic [15:0] acc = 16'h0000;
        for (int kr = 0; kr < K; kr++)
            for (int kc = 0; kc < K; kc++)
                if (wt[m][kr][kc] == 1) acc = img[(orow + kr) * W + ocol + kc];
        return acc;
    endfunction

    task automatic new_image();
        for (int i = 0; i < WH; i++) img[i] = 16'($urandom);
    endtask

    // Called at a negedge; the following posedge accepts start, first read one cycle later.
    task automatic launch();
        exp_t e;
        seq.start = 1'b1;
        job_s     = cyc + 1;
        job_valid = 1'b1;
        for (int m = 0; m < N; m++)
            for (int orow = 0; orow < OH; orow++)
                for (int ocol = 0; ocol < OW; ocol++) begin
                    e.cyc  = job_s + m * P + (orow + K - 1) * W + (ocol + K - 1) + D;
                    e.map  = m;
                    e.addr = m * OW * OH + orow * OW + ocol;
                    e.data = ref_conv(m, orow, ocol);
                    sb.push_back(e);
                end
        @(negedge clk);
        seq.start = 1'b0;
    endtask

    // Timeline checker, conv2d datapath stand-in and y_valid scoreboard monitor.
    always @(negedge clk) begin
        int          n;
        int          k;
        int          t;
        int          lag;
        int          idx;
        bit          inj;
        logic [14:0] act;
        logic [14:0] ex;
        logic [15:0] yout;
        exp_t        e;

        n = cyc;
        if (n < HN) begin
            en_h[n]   = seq.pix_rd_en;
            addr_h[n] = seq.pix_rd_addr;
            map_h[n]  = seq.map_sel;
        end

        k   = n - job_s;
        inj = job_valid && (n >= job_s) && (k < N * P);
        act = {seq.busy, seq.done, seq.pix_rd_en, inj ? seq.map_sel : 2'd0,
               seq.pix_rd_en ? seq.pix_rd_addr : 10'd0};
        if (inj)
            ex = {1'b1, 1'b0, (k % P) < WH, 2'(k / P), ((k % P) < WH) ? 10'(k % P) : 10'd0};
        else if (job_valid && (n >= job_s) && (k == N * P))
            ex = {1'b1, 1'b1, 1'b0, 2'd0, 10'd0};
        else
            ex = '0;
        chk("timeline", 32'(act), 32'(ex));

        if (seq.y_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_y_valid", 32'(seq.y_addr), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                t = n - D;
                lag = 0;
                for (int kr = 0; kr < K; kr++)
                    for (int kc = 0; kc < K; kc++)
                        if (t >= 0 && t < HN && wt[map_h[t]][kr][kc] == 1)
                            lag = (K - 1 - kr) * W + (K - 1 - kc);
                idx  = t - lag;
                yout = (idx >= 0 && idx < HN && en_h[idx] === 1'b1) ? img[addr_h[idx]] : 16'hDEAD;
                chk("y_valid_cycle", 32'(n),          32'(e.cyc));
                chk("y_map",         32'(seq.y_map),  32'(e.map));
                chk("y_addr",        32'(seq.y_addr), 32'(e.addr));
                chk("yout",          32'(yout),       32'(e.data));
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        seq.start = 1'b0;
        for (int m = 0; m < N; m++)
            for (int kr = 0; kr < K; kr++)
                for (int kc = 0; kc < K; kc++)
                    wt[m][kr][kc] = ((kr * K + kc) == ((m * 7 + 3) % (K * K))) ? 1 : 0;

        repeat (3) @(negedge clk);
        #2;
        chk_zero("reset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Job A: full run, stray start mid-job and again while done is high.
        new_image();
        launch();
        while (cyc < job_s + 1000) @(negedge clk);
        seq.start = 1'b1;
        @(negedge clk);
        seq.start = 1'b0;
        while (cyc < job_s + N * P) @(negedge clk);
        seq.start = 1'b1;
        @(negedge clk);
        seq.start = 1'b0;
        repeat (5) @(negedge clk);
        chk("job_a_all_drained", 32'(sb.size()), 0);

        // Job B: reset during STREAM of map 2 aborts everything.
        launch();
        while (cyc < job_s + 2 * P + 300) @(negedge clk);
        #2;
        rst_n     = 1'b0;
        job_valid = 1'b0;
        sb.delete();
        #1;
        chk_zero("abort");
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Job C: fresh image, full run after the abort.
        new_image();
        launch();
        while (cyc < job_s + N * P + 5) @(negedge clk);
        chk("job_c_all_drained", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end

endmodule
